swo_decoder: RTL

Parametrised SWO receiver that recovers 8-bit bytes from the raw SWO pin in either Manchester or NRZ (UART) encoding, selected at run time. It measures the Manchester half-bit length from each packet's start bit, or uses a programmed NRZ divisor, and frames bytes LSB first. Bytes go into a small FIFO with a valid/ready interface to the packet layer above. Framing errors and FIFO overflow are flagged.

---
 rtl/swo_decoder_if.sv | 9 +
 rtl/swo_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/swo_decoder_if.sv
// Byte stream from the SWO decoder to the packet layer: valid/ready handshake.
interface swo_decoder_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/swo_decoder.sv
// SWO receiver: Manchester or NRZ bit recovery, LSB-first byte framing and a
// small output FIFO with sticky overflow and framing-error pulse.
module swo_decoder #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swo,
  input  logic             mode,
  input  logic [CNT_W-1:0] nrz_div,
  input  logic             ovf_clr,
  swo_decoder_if.master    pkt,
  output logic             overflow,
  output logic             err_frame,
  output logic [CNT_W-1:0] halfbit_len
);
  localparam int unsigned W  = CNT_W + 3;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_HB_MEASURE = 3'd1;
  localparam logic [2:0] S_M_BITS     = 3'd2;
  localparam logic [2:0] S_N_START    = 3'd3;
  localparam logic [2:0] S_N_BITS     = 3'd4;
  localparam logic [2:0] S_N_STOP     = 3'd5;
  localparam logic [2:0] S_N_BREAK    = 3'd6;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, edg, rise, fall;
  logic                   mode_q;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt, cnt_inc, half_m1, div_m1;
  logic [W-1:0]           cnt_w, cnt_p1, thr, tmo;
  logic [2:0]             bitcnt;
  logic [7:0]             data_sr, byte_w, push_data;
  logic                   push;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   full, pop, push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], swo};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign edg  = s ^ s_d;
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign cnt_w   = W'(cnt);
  assign cnt_p1  = cnt_w + W'(1);
  assign thr     = (W'(halfbit_len) << 1) - W'(1);
  assign tmo     = W'(halfbit_len) << 3;
  assign half_m1 = (nrz_div >> 1) - CNT_W'(1);
  assign div_m1  = nrz_div - CNT_W'(1);

  // Manchester takes the level before the mid-bit edge, NRZ the level at the sample.
  always_comb begin
    byte_w         = data_sr;
    byte_w[bitcnt] = mode_q ? s : s_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      state       <= S_IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      data_sr     <= '0;
      push        <= 1'b0;
      push_data   <= '0;
      err_frame   <= 1'b0;
      halfbit_len <= '0;
    end else begin
      push      <= 1'b0;
      err_frame <= 1'b0;
      cnt       <= cnt_inc;
      mode_q    <= mode;
      if (mode != mode_q) begin
        state  <= S_IDLE;
        cnt    <= '0;
        bitcnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!mode_q && rise) begin
              state <= S_HB_MEASURE;
              cnt   <= '0;
            end else if (mode_q && fall) begin
              state <= S_N_START;
              cnt   <= '0;
            end
          end
          S_HB_MEASURE: begin
            if (edg) begin
              cnt <= '0;
              if (cnt_p1 < W'(2)) begin
                err_frame <= 1'b1;
                state     <= S_IDLE;
              end else begin
                halfbit_len <= (&cnt) ? '1 : cnt_p1[CNT_W-1:0];
                bitcnt      <= '0;
                state       <= S_M_BITS;
              end
            end
          end
          S_M_BITS: begin
            if (edg && cnt_p1 >= thr) begin
              cnt     <= '0;
              data_sr <= byte_w;
              bitcnt  <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                push      <= 1'b1;
                push_data <= byte_w;
              end
            end else if (cnt_w > tmo) begin
              state     <= S_IDLE;
              cnt       <= '0;
              err_frame <= (bitcnt != 3'd0);
              bitcnt    <= '0;
            end
          end
          S_N_START: begin
            if (cnt == half_m1) begin
              cnt    <= '0;
              bitcnt <= '0;
              state  <= s ? S_IDLE : S_N_BITS;
            end
          end
          S_N_BITS: begin
            if (cnt == div_m1) begin
              cnt     <= '0;
              data_sr <= byte_w;
              bitcnt  <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= S_N_STOP;
            end
          end
          S_N_STOP: begin
            if (cnt == div_m1) begin
              cnt <= '0;
              if (s) begin
                push      <= 1'b1;
                push_data <= data_sr;
                state     <= S_IDLE;
              end else begin
                err_frame <= 1'b1;
                state     <= S_N_BREAK;
              end
            end
          end
          S_N_BREAK: begin
            if (s) begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = pkt.out_valid & pkt.out_ready;
  assign push_ok = push & (~full | pop);

  assign pkt.out_valid = (wr_ptr != rd_ptr);
  assign pkt.out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end
endmodule
